// File: rtl/div_iter_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The pipeline side is the master; the divider is the slave.
interface div_iter_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            busy;

    modport master (
        output req_valid, req_op, req_a, req_b, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per
// cycle, with divide-by-zero and signed overflow resolved at acceptance.
module div_iter_unit #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    div_iter_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [1:0]      op;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   rem;
    logic            neg_q;
    logic            neg_r;

    // acceptance-side decode
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;
    logic            accept;

    always_comb begin
        is_signed = ~bus.req_op[0];
        a_neg     = is_signed & bus.req_a[XLEN-1];
        b_neg     = is_signed & bus.req_b[XLEN-1];
        a_mag     = a_neg ? -bus.req_a : bus.req_a;
        b_mag     = b_neg ? -bus.req_b : bus.req_b;
        div_zero  = (bus.req_b == '0);
        ovf       = is_signed && (bus.req_a == INT_MIN) && (bus.req_b == '1);
        accept    = bus.req_valid && (state == S_IDLE) && !bus.flush;
    end

    // one restoring step: rem is XLEN+1 wide so the trial subtract cannot wrap
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        shifted = {rem[XLEN-1:0], quo[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
        fits    = ~diff[XLEN];
    end

    // result select and sign fix-up; fast-path entries leave both flags clear
    logic [XLEN-1:0] sel;
    logic            neg;
    logic [XLEN-1:0] res;

    always_comb begin
        sel = op[1] ? rem[XLEN-1:0] : quo;
        neg = op[1] ? neg_r : neg_q;
        res = neg ? -sel : sel;
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.rsp_valid  = (state == S_DONE);
    assign bus.rsp_result = (state == S_DONE) ? res : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op    <= '0;
            cnt   <= '0;
            quo   <= '0;
            dvs   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op <= bus.req_op;
                        if (div_zero) begin
                            quo   <= '1;
                            rem   <= {1'b0, bus.req_a};
                            dvs   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= S_DONE;
                        end else if (ovf) begin
                            quo   <= INT_MIN;
                            rem   <= '0;
                            dvs   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            dvs   <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            cnt   <= CW'(XLEN-1);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= fits ? diff : shifted;
                    quo <= {quo[XLEN-2:0], fits};
                    if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_DONE: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: expected results are queued at issue
// and compared, together with latency, when rsp_valid is seen.
module tb_div_iter_unit;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] exp_q[$];

    div_iter_unit_if #(.XLEN(XLEN)) bus ();

    div_iter_unit #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1; r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Returns just after the acceptance edge with req_valid dropped.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit track);
        int w;
        w = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (track) exp_q.push_back(exp);
    endtask

    // edges: acceptance-relative index of the edge after which rsp_valid is first seen
    task automatic collect(input string tag, input int exp_edges);
        int edges;
        logic [31:0] exp;
        edges = 0;
        @(negedge clk);
        while (!bus.rsp_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!bus.rsp_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_lat"}, edges, exp_edges);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk(tag, bus.rsp_result, exp);
        if (bus.rsp_ready) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
        issue(op, a, b, exp, 1'b1);
        collect(tag, exp_edges);
    endtask

    task automatic watch_silent(input string tag);
        int hits;
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid) hits++;
        end
        chk(tag, hits, 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;

        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", bus.rsp_result, 32'd0);
        #9 rst_n = 1'b1;

        run("div_20_m3",   OP_DIV,  32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 32);
        run("rem_20_m3",   OP_REM,  32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002, 32);
        run("divu_max_2",  OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 32);
        run("remu_max_2",  OP_REMU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32);
        run("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32);
        run("div_7_0",     OP_DIV,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run("divu_0_0",    OP_DIVU, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run("rem_x_0",     OP_REM,  32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 0);
        run("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run("divu_ovf",    OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32);

        // backpressure with a second request queued behind the held response
        bus.rsp_ready = 1'b0;
        run("bp_first", OP_DIVU, 32'd1000, 32'd10, 32'd100, 32);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV;
        bus.req_a     = 32'h0000_0014;
        bus.req_b     = 32'hFFFF_FFFD;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_hold", bus.rsp_result, 32'd100);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_rdy", 32'(bus.req_ready), 32'd1);
        chk("bp_release_vld", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFA);
        collect("bp_queued", 32);

        // flush sampled on the edge of iteration 10
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_rdy", 32'(bus.req_ready), 32'd1);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        watch_silent("flush_no_rsp");

        // asynchronous reset mid-iteration
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_result", bus.rsp_result, 32'd0);
        #1 rst_n = 1'b1;
        watch_silent("arst_no_rsp");
        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run($sformatf("rnd%0d", i), op, a, b, model(op, a, b), is_fast(op, a, b) ? 0 : 32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
